// File: rtl/pipeline_ctrl.sv
// Run/stall/flush sequencer for the 4-stage 8-bit CPU pipeline.
// Optional single-step mode is built when PIPE_CTRL_STEP_EN is defined.
//
// state  | meaning
// IDLE   | PC held in reset, latches loaded with NOPs, waiting for run_i
// RUN    | pipeline advancing, stalling on hazards, acting on branch/HALT
// DRAIN  | HALT seen, retiring the EX and WB instructions
// HALTED | stopped with PC preserved, waiting for a run_i rising edge
module pipeline_ctrl #(
    parameter int unsigned STALL_CNT_W = 8,
    parameter bit          WB_BYPASS   = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   run_i,
    input  logic [2:0]             dec_rd_a_i,
    input  logic [2:0]             dec_rd_b_i,
    input  logic                   dec_use_a_i,
    input  logic                   dec_use_b_i,
    input  logic                   dec_branch_i,
    input  logic                   dec_halt_i,
    input  logic                   ex_wr_en_i,
    input  logic [2:0]             ex_wr_addr_i,
    input  logic                   wb_wr_en_i,
    input  logic [2:0]             wb_wr_addr_i,
    input  logic                   step_i,
    output logic                   pc_rst_o,
    output logic                   fetch_en_o,
    output logic                   fetch_flush_o,
    output logic                   bubble_o,
    output logic                   branch_en_o,
    output logic [1:0]             state_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [1:0]             drain_cnt_q, drain_cnt_d;
    logic                   run_prev_q;
    logic                   hazard;
    logic                   advance_ok;
    logic                   step_pend_d;

    function automatic logic match(input logic [2:0] r);
        return (ex_wr_en_i && (ex_wr_addr_i == r)) ||
               (!WB_BYPASS && wb_wr_en_i && (wb_wr_addr_i == r));
    endfunction

    assign hazard = (dec_use_a_i && match(dec_rd_a_i)) ||
                    (dec_use_b_i && match(dec_rd_b_i));

`ifdef PIPE_CTRL_STEP_EN
    logic step_prev_q;
    logic step_pend_q;
    logic step_rise;

    assign step_rise  = step_i && !step_prev_q;
    assign advance_ok = step_pend_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            step_prev_q <= 1'b0;
            step_pend_q <= 1'b0;
        end else begin
            step_prev_q <= step_i;
            step_pend_q <= step_pend_d;
        end
    end
`else
    logic unused_step;
    assign unused_step = step_i;
    assign advance_ok  = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            stall_cnt_q <= '0;
            drain_cnt_q <= 2'd0;
            run_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            run_prev_q  <= run_i;
        end
    end

    always_comb begin
        state_d       = state_q;
        stall_cnt_d   = stall_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        pc_rst_o      = 1'b0;
        fetch_en_o    = 1'b0;
        fetch_flush_o = 1'b0;
        bubble_o      = 1'b0;
        branch_en_o   = 1'b0;
`ifdef PIPE_CTRL_STEP_EN
        step_pend_d   = 1'b0;
`else
        step_pend_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                pc_rst_o      = 1'b1;
                fetch_flush_o = 1'b1;
                bubble_o      = 1'b1;
                if (run_i) begin
                    state_d     = RUN;
                    stall_cnt_d = '0;
                end
            end
            RUN: begin
`ifdef PIPE_CTRL_STEP_EN
                step_pend_d = step_pend_q || step_rise;
`endif
                if (hazard) begin
                    bubble_o    = 1'b1;
                    stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 1'b1;
                end else if (!advance_ok) begin
                    bubble_o = 1'b1;
                end else begin
`ifdef PIPE_CTRL_STEP_EN
                    // the pending step is consumed; a fresh edge this cycle queues the next one
                    step_pend_d = step_rise;
`endif
                    if (dec_halt_i) begin
                        fetch_flush_o = 1'b1;
                        bubble_o      = 1'b1;
                        state_d       = DRAIN;
                        drain_cnt_d   = 2'd2;
                    end else if (dec_branch_i) begin
                        branch_en_o   = 1'b1;
                        fetch_en_o    = 1'b1;
                        fetch_flush_o = 1'b1;
                    end else begin
                        fetch_en_o = 1'b1;
                    end
                end
            end
            DRAIN: begin
                fetch_flush_o = 1'b1;
                bubble_o      = 1'b1;
                drain_cnt_d   = drain_cnt_q - 2'd1;
                if (drain_cnt_q == 2'd1) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                fetch_flush_o = 1'b1;
                bubble_o      = 1'b1;
                // only a fresh edge restarts; a level left high from the last start does not
                if (run_i && !run_prev_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected outputs are queued as each cycle is
// driven and popped for comparison mid-cycle; a WB_BYPASS=1 copy shares the inputs.
module tb_pipeline_ctrl;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [2:0] rd_a, rd_b, ex_addr, wb_addr;
    logic       use_a, use_b, br, halt, ex_en, wb_en, step;

    logic       pc_rst, fetch_en, flush, bubble, br_en;
    logic [1:0] state;
    logic [7:0] stall_cnt;
    logic       pc_rst_bp, fetch_en_bp, flush_bp, bubble_bp, br_en_bp;
    logic [1:0] state_bp;
    logic [7:0] stall_cnt_bp;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] st;
        logic       pc_rst;
        logic       fetch;
        logic       flush;
        logic       bubble;
        logic       br;
        logic [7:0] stall;
        logic       fetch_bp;
    } exp_t;

    exp_t exp_q[$];

    pipeline_ctrl #(.STALL_CNT_W(8), .WB_BYPASS(1'b0)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .run_i(run),
        .dec_rd_a_i(rd_a), .dec_rd_b_i(rd_b), .dec_use_a_i(use_a), .dec_use_b_i(use_b),
        .dec_branch_i(br), .dec_halt_i(halt),
        .ex_wr_en_i(ex_en), .ex_wr_addr_i(ex_addr), .wb_wr_en_i(wb_en), .wb_wr_addr_i(wb_addr),
        .step_i(step),
        .pc_rst_o(pc_rst), .fetch_en_o(fetch_en), .fetch_flush_o(flush), .bubble_o(bubble),
        .branch_en_o(br_en), .state_o(state), .stall_cnt_o(stall_cnt)
    );

    pipeline_ctrl #(.STALL_CNT_W(8), .WB_BYPASS(1'b1)) dut_bp (
        .clk_i(clk), .rst_n_i(rst_n), .run_i(run),
        .dec_rd_a_i(rd_a), .dec_rd_b_i(rd_b), .dec_use_a_i(use_a), .dec_use_b_i(use_b),
        .dec_branch_i(br), .dec_halt_i(halt),
        .ex_wr_en_i(ex_en), .ex_wr_addr_i(ex_addr), .wb_wr_en_i(wb_en), .wb_wr_addr_i(wb_addr),
        .step_i(step),
        .pc_rst_o(pc_rst_bp), .fetch_en_o(fetch_en_bp), .fetch_flush_o(flush_bp), .bubble_o(bubble_bp),
        .branch_en_o(br_en_bp), .state_o(state_bp), .stall_cnt_o(stall_cnt_bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] st, input logic pr, input logic fe, input logic fl,
                                input logic bu, input logic b, input logic [7:0] sc, input logic fbp);
        exp_t e;
        e.st = st; e.pc_rst = pr; e.fetch = fe; e.flush = fl;
        e.bubble = bu; e.br = b; e.stall = sc; e.fetch_bp = fbp;
        return e;
    endfunction

    // hz: 0 none, 1 EX writes r2 read on A, 2 WB writes r5 read on B,
    //     3 EX writes r0 read on A, 4 EX writes r0 but A not used
    task automatic cyc(input string tag, input logic r, input int hz, input logic b, input logic h,
                       input exp_t e);
        exp_t got;
        run = r; br = b; halt = h;
        use_a = 1'b0; use_b = 1'b0; rd_a = 3'd1; rd_b = 3'd1;
        ex_en = 1'b0; ex_addr = 3'd7; wb_en = 1'b0; wb_addr = 3'd6;
        case (hz)
            1: begin use_a = 1'b1; rd_a = 3'd2; ex_en = 1'b1; ex_addr = 3'd2; end
            2: begin use_b = 1'b1; rd_b = 3'd5; wb_en = 1'b1; wb_addr = 3'd5; end
            3: begin use_a = 1'b1; rd_a = 3'd0; ex_en = 1'b1; ex_addr = 3'd0; end
            4: begin use_a = 1'b0; rd_a = 3'd0; ex_en = 1'b1; ex_addr = 3'd0; end
            default: ;
        endcase
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        chk({tag, ".state"},    {6'd0, state},    {6'd0, got.st});
        chk({tag, ".pc_rst"},   {7'd0, pc_rst},   {7'd0, got.pc_rst});
        chk({tag, ".fetch_en"}, {7'd0, fetch_en}, {7'd0, got.fetch});
        chk({tag, ".flush"},    {7'd0, flush},    {7'd0, got.flush});
        chk({tag, ".bubble"},   {7'd0, bubble},   {7'd0, got.bubble});
        chk({tag, ".branch"},   {7'd0, br_en},    {7'd0, got.br});
        chk({tag, ".stall"},    stall_cnt,        got.stall);
        chk({tag, ".bp_fetch"}, {7'd0, fetch_en_bp}, {7'd0, got.fetch_bp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; step = 1'b0;
        use_a = 1'b0; use_b = 1'b0; rd_a = 3'd0; rd_b = 3'd0; br = 1'b0; halt = 1'b0;
        ex_en = 1'b0; ex_addr = 3'd0; wb_en = 1'b0; wb_addr = 3'd0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst.state",  {6'd0, state},    8'd0);
        chk("rst.pc_rst", {7'd0, pc_rst},   8'd1);
        chk("rst.fetch",  {7'd0, fetch_en}, 8'd0);
        chk("rst.flush",  {7'd0, flush},    8'd1);
        chk("rst.bubble", {7'd0, bubble},   8'd1);
        chk("rst.branch", {7'd0, br_en},    8'd0);
        chk("rst.stall",  stall_cnt,        8'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //                                  st pr fe fl bu br stall bp
        cyc("idle_go",   1, 0, 0, 0, mk(2'd0, 1, 0, 1, 1, 0, 8'd0, 0));
        cyc("run",       1, 0, 0, 0, mk(2'd1, 0, 1, 0, 0, 0, 8'd0, 1));
        cyc("ex_haz",    1, 1, 0, 0, mk(2'd1, 0, 0, 0, 1, 0, 8'd0, 0));
        cyc("after_haz", 1, 0, 0, 0, mk(2'd1, 0, 1, 0, 0, 0, 8'd1, 1));
        cyc("wb_haz",    1, 2, 0, 0, mk(2'd1, 0, 0, 0, 1, 0, 8'd1, 1));
        cyc("branch",    1, 0, 1, 0, mk(2'd1, 0, 1, 1, 0, 1, 8'd2, 1));
        cyc("br_haz",    1, 1, 1, 0, mk(2'd1, 0, 0, 0, 1, 0, 8'd2, 0));
        cyc("br_late",   1, 0, 1, 0, mk(2'd1, 0, 1, 1, 0, 1, 8'd3, 1));
        cyc("r0_haz",    1, 3, 0, 0, mk(2'd1, 0, 0, 0, 1, 0, 8'd3, 0));
        cyc("unused_a",  0, 4, 0, 0, mk(2'd1, 0, 1, 0, 0, 0, 8'd4, 1));
        cyc("halt_br",   0, 0, 1, 1, mk(2'd1, 0, 0, 1, 1, 0, 8'd4, 0));
        cyc("drain1",    0, 0, 1, 0, mk(2'd2, 0, 0, 1, 1, 0, 8'd4, 0));
        cyc("drain2",    0, 0, 0, 0, mk(2'd2, 0, 0, 1, 1, 0, 8'd4, 0));
        cyc("halted",    0, 0, 0, 0, mk(2'd3, 0, 0, 1, 1, 0, 8'd4, 0));
        cyc("halt_rise", 1, 0, 0, 0, mk(2'd3, 0, 0, 1, 1, 0, 8'd4, 0));
        cyc("restart",   1, 0, 0, 0, mk(2'd0, 1, 0, 1, 1, 0, 8'd4, 0));
        cyc("rerun",     1, 0, 0, 0, mk(2'd1, 0, 1, 0, 0, 0, 8'd0, 1));
        cyc("halt2",     1, 0, 0, 1, mk(2'd1, 0, 0, 1, 1, 0, 8'd0, 0));
        cyc("drain2_1",  1, 0, 0, 0, mk(2'd2, 0, 0, 1, 1, 0, 8'd0, 0));
        cyc("drain2_2",  1, 0, 0, 0, mk(2'd2, 0, 0, 1, 1, 0, 8'd0, 0));
        cyc("lvl_hold1", 1, 0, 0, 0, mk(2'd3, 0, 0, 1, 1, 0, 8'd0, 0));
        cyc("lvl_hold2", 1, 0, 0, 0, mk(2'd3, 0, 0, 1, 1, 0, 8'd0, 0));
        cyc("run_low",   0, 0, 0, 0, mk(2'd3, 0, 0, 1, 1, 0, 8'd0, 0));
        cyc("run_rise",  1, 0, 0, 0, mk(2'd3, 0, 0, 1, 1, 0, 8'd0, 0));
        cyc("restart2",  1, 0, 0, 0, mk(2'd0, 1, 0, 1, 1, 0, 8'd0, 0));

        for (int i = 0; i < 300; i++) begin
            cyc($sformatf("sat%0d", i), 1, 1, 0, 0,
                mk(2'd1, 0, 0, 0, 1, 0, (i > 255) ? 8'd255 : 8'(i), 0));
        end
        cyc("sat_hold",  1, 0, 0, 0, mk(2'd1, 0, 1, 0, 0, 0, 8'd255, 1));

        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.state",  {6'd0, state},    8'd0);
        chk("arst.pc_rst", {7'd0, pc_rst},   8'd1);
        chk("arst.fetch",  {7'd0, fetch_en}, 8'd0);
        chk("arst.stall",  stall_cnt,        8'd0);
        chk("arst.bp_st",  {6'd0, state_bp}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
